// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, direction constants and quadrature step table
package motor_pkg;

  typedef logic [1:0] enc_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t;

  // Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward; both bits flipping is illegal.
  function automatic step_t step_decode(enc_state_t prev, enc_state_t next);
    step_t      res;
    enc_state_t fwd_next;
    unique case (prev)
      2'b00:   fwd_next = 2'b01;
      2'b01:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b10;
      default: fwd_next = 2'b00;
    endcase
    if (prev == next)               res = STEP_NONE;
    else if ((prev ^ next) == 2'b11) res = STEP_ILLEGAL;
    else if (next == fwd_next)      res = STEP_FWD;
    else                            res = STEP_REV;
    return res;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// rtl/enc_input_filter.sv - A/B synchroniser plus joint stability filter with update strobe
module enc_input_filter
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  output enc_state_t filtered,
  output logic       update
);

  enc_state_t sync_q [SYNC_STAGES];
  enc_state_t sync_out;
  enc_state_t sync_prev;
  logic [7:0] stable_cnt;
  logic [7:0] cnt_next;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A fresh value on the synchronised pair restarts the run length at one.
  always_comb begin
    cnt_next = (sync_out != sync_prev) ? 8'd1 : stable_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_prev  <= '0;
      stable_cnt <= '0;
      filtered   <= '0;
      update     <= 1'b0;
    end else begin
      sync_q[0] <= {enc_a, enc_b};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_out;
      update    <= 1'b0;
      if (sync_out == filtered) begin
        stable_cnt <= '0;
      end else if (cnt_next == 8'(FILT_LEN)) begin
        filtered   <= sync_out;
        update     <= 1'b1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_reader.sv
// rtl/quad_encoder_reader.sv - x4 quadrature decoder with position, windowed velocity and error flag
module quad_encoder_reader
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_LEN      = 4,
  parameter int POS_WIDTH     = 32,
  parameter int VEL_WIDTH     = 16,
  parameter int SAMPLE_CYCLES = 500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        clear_pos,
  input  logic                        err_clear,
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        vel_valid,
  output logic                        dir,
  output logic                        err
);

  localparam int WIN_W = $clog2(SAMPLE_CYCLES);

  enc_state_t                 filtered;
  enc_state_t                 prev_state;
  logic                       update;
  logic                       primed;
  step_t                      step;
  logic signed [POS_WIDTH-1:0] step_val;
  logic signed [POS_WIDTH-1:0] accum;
  logic signed [VEL_WIDTH-1:0] vel_sat;
  logic [WIN_W-1:0]           win_cnt;
  logic                       win_end;

  enc_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .filtered(filtered),
    .update  (update)
  );

  // The first accepted level after reset only seeds prev_state.
  always_comb begin
    step = STEP_NONE;
    if (update && primed) step = step_decode(prev_state, filtered);
  end

  always_comb begin
    step_val = '0;
    if (step == STEP_FWD)      step_val = POS_WIDTH'(1);
    else if (step == STEP_REV) step_val = '1;
  end

  assign win_end = (win_cnt == WIN_W'(SAMPLE_CYCLES - 1));

  generate
    if (VEL_WIDTH < POS_WIDTH) begin : g_sat
      always_comb begin
        if ((&accum[POS_WIDTH-1:VEL_WIDTH-1]) || !(|accum[POS_WIDTH-1:VEL_WIDTH-1]))
          vel_sat = accum[VEL_WIDTH-1:0];
        else if (accum[POS_WIDTH-1])
          vel_sat = {1'b1, {(VEL_WIDTH-1){1'b0}}};
        else
          vel_sat = {1'b0, {(VEL_WIDTH-1){1'b1}}};
      end
    end else begin : g_ext
      assign vel_sat = VEL_WIDTH'(accum);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= '0;
      primed     <= 1'b0;
      position   <= '0;
      velocity   <= '0;
      vel_valid  <= 1'b0;
      dir        <= DIR_REV;
      err        <= 1'b0;
      win_cnt    <= '0;
      accum      <= '0;
    end else begin
      if (update) begin
        prev_state <= filtered;
        primed     <= 1'b1;
      end
      if (clear_pos) position <= '0;
      else           position <= position + step_val;
      if (step == STEP_FWD)      dir <= DIR_FWD;
      else if (step == STEP_REV) dir <= DIR_REV;
      if (step == STEP_ILLEGAL) err <= 1'b1;
      else if (err_clear)       err <= 1'b0;
      vel_valid <= win_end;
      // The terminal-cycle step opens the next window rather than closing this one.
      if (win_end) begin
        win_cnt  <= '0;
        velocity <= vel_sat;
        accum    <= step_val;
      end else begin
        win_cnt  <= win_cnt + WIN_W'(1);
        accum    <= accum + step_val;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// tb/tb_quad_encoder_reader.sv - self-checking bench for quad_encoder_reader
module tb_quad_encoder_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tie0 = 1'b0;
  always #10 clk = ~clk;

  logic pa = 0, pb = 0, clr_m = 0, ec_m = 0;
  logic signed [31:0] pos_m;
  logic signed [15:0] vel_m;
  logic vv_m, dir_m, err_m;

  logic va = 0, vb = 0, clr_v = 0;
  logic signed [31:0] pos_v;
  logic signed [15:0] vel_v;
  logic vv_v, dir_v, err_v;

  logic sa = 0, sb = 0;
  logic signed [31:0] pos_s;
  logic signed [3:0]  vel_s;
  logic vv_s, dir_s, err_s;
  logic signed [3:0]  pos_w;
  logic signed [3:0]  vel_w;
  logic vv_w, dir_w, err_w;

  quad_encoder_reader dut_m (
    .clk(clk), .rst(rst), .enc_a(pa), .enc_b(pb), .clear_pos(clr_m), .err_clear(ec_m),
    .position(pos_m), .velocity(vel_m), .vel_valid(vv_m), .dir(dir_m), .err(err_m));

  quad_encoder_reader #(.FILT_LEN(1), .SAMPLE_CYCLES(100)) dut_v (
    .clk(clk), .rst(rst), .enc_a(va), .enc_b(vb), .clear_pos(clr_v), .err_clear(tie0),
    .position(pos_v), .velocity(vel_v), .vel_valid(vv_v), .dir(dir_v), .err(err_v));

  quad_encoder_reader #(.FILT_LEN(1), .SAMPLE_CYCLES(100), .VEL_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .enc_a(sa), .enc_b(sb), .clear_pos(tie0), .err_clear(tie0),
    .position(pos_s), .velocity(vel_s), .vel_valid(vv_s), .dir(dir_s), .err(err_s));

  quad_encoder_reader #(.FILT_LEN(1), .SAMPLE_CYCLES(100), .POS_WIDTH(4), .VEL_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .enc_a(sa), .enc_b(sb), .clear_pos(tie0), .err_clear(tie0),
    .position(pos_w), .velocity(vel_w), .vel_valid(vv_w), .dir(dir_w), .err(err_w));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_m[$];
  int q_v[$];
  int q_s[$];
  logic mon_v_en = 1'b1;
  logic mon_s_en = 1'b1;
  int last_v = -1;
  int last_s = -1;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  typedef struct {
    logic a;
    logic b;
    int   exp_pos;
    logic exp_dir;
    logic exp_err;
  } vec_t;
  vec_t tbl [17];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur", name);
  endtask

  task automatic wait_pulse(input int which, input string name);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if ((which == 0) ? vv_v : vv_s) return;
    end
    fail(name);
  endtask

  always @(negedge clk) begin
    if (mon_v_en && vv_v) begin
      if (q_v.size() == 0) fail("vel_v_unexpected");
      else check("vel_v", vel_v, q_v.pop_front());
      if (last_v >= 0) check("win_len_v", cyc - last_v, 100);
      last_v = cyc;
    end
    if (mon_s_en && vv_s) begin
      if (q_s.size() == 0) fail("vel_s_unexpected");
      else check("vel_s", vel_s, q_s.pop_front());
      if (last_s >= 0) check("win_len_s", cyc - last_s, 100);
      last_s = cyc;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 3, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 6, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 7, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 7, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 6, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 5, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 6, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 7, 1'b1, 1'b1};

    #5;
    check("rst_pos", pos_m, 0);
    check("rst_vel", vel_m, 0);
    check("rst_vv", vv_m, 0);
    check("rst_dir", dir_m, 0);
    check("rst_err", err_m, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    fork
      begin : grp_main
        int prev;
        prev = 0;
        for (int i = 0; i < 17; i++) begin
          @(negedge clk);
          pa = tbl[i].a; pb = tbl[i].b;
          q_m.push_back(tbl[i].exp_pos);
          repeat (6) @(posedge clk); #1;
          check($sformatf("lat_hold[%0d]", i), pos_m, prev);
          @(posedge clk); #1;
          check($sformatf("pos[%0d]", i), pos_m, q_m.pop_front());
          check($sformatf("dir[%0d]", i), dir_m, tbl[i].exp_dir);
          check($sformatf("err[%0d]", i), err_m, tbl[i].exp_err);
          prev = tbl[i].exp_pos;
          repeat (3) @(posedge clk);
        end
        @(negedge clk); ec_m = 1'b1;
        @(posedge clk); #1;
        check("err_clear", err_m, 0);
        ec_m = 1'b0;
        // three-cycle pulse on b must be swallowed
        @(negedge clk); pb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); pb = 1'b0;
        repeat (12) @(posedge clk); #1;
        check("glitch3_pos", pos_m, 7);
        check("glitch3_err", err_m, 0);
        @(negedge clk); pb = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); pb = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("hold4_before", pos_m, 7);
        @(posedge clk); #1;
        check("hold4_pos", pos_m, 8);
        check("hold4_dir", dir_m, 1);
        repeat (10) @(posedge clk); #1;
        check("hold4_back_pos", pos_m, 7);
        check("hold4_back_dir", dir_m, 0);
        @(negedge clk); pa = 1'b1; pb = 1'b1;
        repeat (6) @(posedge clk); #1;
        ec_m = 1'b1;
        @(posedge clk); #1;
        ec_m = 1'b0;
        check("err_set_wins", err_m, 1);
        check("illegal_pos", pos_m, 7);
        check("illegal_dir", dir_m, 0);
        @(negedge clk); pb = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("after_illegal_pos", pos_m, 8);
      end
      begin : grp_vel
        int idx;
        repeat (3) @(negedge clk);
        va = 1'b1; vb = 1'b0;
        q_v.push_back(0);
        wait_pulse(0, "pulse_v1");
        q_v.push_back(5);
        idx = 3;
        for (int k = 0; k < 5; k++) begin
          idx = (idx + 1) % 4;
          @(negedge clk); {va, vb} = gray[idx];
          repeat (6) @(posedge clk);
        end
        wait_pulse(0, "pulse_v2");
        q_v.push_back(-3);
        for (int k = 0; k < 3; k++) begin
          idx = (idx + 3) % 4;
          @(negedge clk); {va, vb} = gray[idx];
          repeat (6) @(posedge clk);
        end
        #1 check("pos_v_net", pos_v, 2);
        wait_pulse(0, "pulse_v3");
        q_v.push_back(1);
        @(negedge clk); va = 1'b1; vb = 1'b1;
        repeat (3) @(posedge clk); #1;
        clr_v = 1'b1;
        @(posedge clk); #1;
        clr_v = 1'b0;
        check("clear_pos", pos_v, 0);
        repeat (3) @(posedge clk); #1;
        check("clear_pos_hold", pos_v, 0);
        wait_pulse(0, "pulse_v4");
        @(negedge clk); #1 mon_v_en = 1'b0;
        check("q_v_drained", q_v.size(), 0);
      end
      begin : grp_sat
        int idx;
        repeat (3) @(negedge clk);
        sa = 1'b1; sb = 1'b0;
        q_s.push_back(0);
        wait_pulse(1, "pulse_s1");
        q_s.push_back(7);
        idx = 3;
        for (int k = 1; k <= 10; k++) begin
          idx = (idx + 1) % 4;
          @(negedge clk); {sa, sb} = gray[idx];
          repeat (6) @(posedge clk); #1;
          if (k == 7) check("wrap_max", pos_w, 7);
          if (k == 8) check("wrap_min", pos_w, -8);
        end
        check("pos_s_10", pos_s, 10);
        wait_pulse(1, "pulse_s2");
        @(negedge clk); #1 mon_s_en = 1'b0;
        check("q_s_drained", q_s.size(), 0);
      end
    join

    @(negedge clk); #3;
    rst = 1'b1;
    pa = 1'b1; pb = 1'b1;
    #1;
    check("async_rst_pos", pos_m, 0);
    check("async_rst_dir", dir_m, 0);
    check("async_rst_err", err_m, 0);
    check("async_rst_pos_v", pos_v, 0);
    check("async_rst_vel_v", vel_v, 0);
    check("async_rst_vel_s", vel_s, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("reprime_pos", pos_m, 0);
    check("reprime_err", err_m, 0);
    check("reprime_dir", dir_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
